// File: rtl/lcd_bus_arbiter_if.sv
// ============================================================================
// Module      : lcd_bus_arbiter_if
// Description : Requester handshake and HD44780-style LCD write bus bundle for
//               lcd_bus_arbiter. The slave modport is the arbiter's view. The
//               master modport is the requester/LCD side.
//               req_valid/req_rs/req_last : per-requester byte qualifiers
//               req_data                  : requester i on [8i+7:8i]
//               req_ready/grant           : per-requester accept strobe / owner
//               busy,E,RS,RW,DATA         : arbiter status and LCD pins
//               timeout                   : present only with LCD_ARB_TIMEOUT_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lcd_bus_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_rs;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic                 E;
    logic                 RS;
    logic                 RW;
    logic [7:0]           DATA;
`ifdef LCD_ARB_TIMEOUT_EN
    logic                 timeout;
`endif

    modport slave (
        input  req_valid, req_rs, req_data, req_last,
        output req_ready, grant, busy, E, RS, RW, DATA
`ifdef LCD_ARB_TIMEOUT_EN
        , output timeout
`endif
    );

    modport master (
        output req_valid, req_rs, req_data, req_last,
        input  req_ready, grant, busy, E, RS, RW, DATA
`ifdef LCD_ARB_TIMEOUT_EN
        , input timeout
`endif
    );
endinterface

`default_nettype wire

// File: rtl/lcd_bus_arbiter.sv
// ============================================================================
// Module      : lcd_bus_arbiter
// Description : Round-robin arbiter sharing one HD44780-style LCD write bus
//               between NUM_REQ requesters. Bursts are atomic (grant held
//               until a byte flagged last has been written). Each byte gets
//               setup, E pulse, hold and a busy wait (longer after clear/home).
// Ports       : clock - system clock, all state on posedge
//               reset - asynchronous, active-high
//               bus   - lcd_bus_arbiter_if.slave (requester handshake + LCD pins)
// Option      : LCD_ARB_TIMEOUT_EN adds bus.timeout and abandons a burst whose
//               owner stays idle for TIMEOUT_CYCLES cycles in ACCEPT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_bus_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int E_HIGH_CYCLES  = 2,
    parameter int BUSY_CYCLES    = 40,
    parameter int CLEAR_CYCLES   = 1600,
    parameter int TIMEOUT_CYCLES = 255
) (
    input wire logic          clock,
    input wire logic          reset,
    lcd_bus_arbiter_if.slave  bus
);
    localparam int c_max_a   = (CLEAR_CYCLES > TIMEOUT_CYCLES) ? CLEAR_CYCLES : TIMEOUT_CYCLES;
    localparam int c_max_cnt = (c_max_a > E_HIGH_CYCLES) ? c_max_a : E_HIGH_CYCLES;
    localparam int c_cnt_w   = $clog2(c_max_cnt + 1);
    localparam int c_idx_w   = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_SETUP  = 3'd2,
        S_PULSE  = 3'd3,
        S_HOLD   = 3'd4,
        S_WAIT   = 3'd5
    } state_t;

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [c_idx_w-1:0]   r_gidx;
    logic [c_idx_w-1:0]   r_rr;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_E;
    logic                 r_RS;
    logic [7:0]           r_DATA;
    logic                 r_last;
`ifdef LCD_ARB_TIMEOUT_EN
    logic                 r_timeout;
`endif

    logic                 w_found;
    logic [c_idx_w-1:0]   w_next;
    logic                 w_valid_g;
    logic                 w_clear;

    // First valid requester searching upward from the one after the last owner.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_next  = r_rr;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(r_rr) + k) % NUM_REQ;
            if (!w_found && bus.req_valid[idx]) begin
                w_found = 1'b1;
                w_next  = c_idx_w'(idx);
            end
        end
    end

    assign w_valid_g = bus.req_valid[r_gidx];

    // Clear (0x01) and home (0x02/0x03) commands need the long wait.
    assign w_clear = !r_RS && (r_DATA == 8'h01 || r_DATA == 8'h02 || r_DATA == 8'h03);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_rr      <= c_idx_w'(NUM_REQ - 1);
            r_cnt     <= '0;
            r_E       <= 1'b0;
            r_RS      <= 1'b0;
            r_DATA    <= 8'h00;
            r_last    <= 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef LCD_ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_found) begin
                        r_grant <= NUM_REQ'(1) << w_next;
                        r_gidx  <= w_next;
                        r_state <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (w_valid_g) begin
                        r_RS    <= bus.req_rs[r_gidx];
                        r_DATA  <= bus.req_data[{r_gidx, 3'b000} +: 8];
                        r_last  <= bus.req_last[r_gidx];
                        r_cnt   <= '0;
                        r_state <= S_SETUP;
                    end
`ifdef LCD_ARB_TIMEOUT_EN
                    // Owner went quiet mid-burst: abandon it and release the bus.
                    else if (r_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1)) begin
                        r_timeout <= 1'b1;
                        r_rr      <= r_gidx;
                        r_grant   <= '0;
                        r_cnt     <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
`endif
                end
                S_SETUP: begin
                    r_E     <= 1'b1;
                    r_cnt   <= c_cnt_w'(E_HIGH_CYCLES - 1);
                    r_state <= S_PULSE;
                end
                S_PULSE: begin
                    if (r_cnt == '0) begin
                        r_E     <= 1'b0;
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                S_HOLD: begin
                    r_cnt   <= w_clear ? c_cnt_w'(CLEAR_CYCLES - 1) : c_cnt_w'(BUSY_CYCLES - 1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        if (r_last) begin
                            r_rr    <= r_gidx;
                            r_grant <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_ACCEPT;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                default: begin
                    r_E     <= 1'b0;
                    r_grant <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_grant & {NUM_REQ{r_state == S_ACCEPT}};
    assign bus.grant     = r_grant;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.E         = r_E;
    assign bus.RS        = r_RS;
    assign bus.RW        = 1'b0;
    assign bus.DATA      = r_DATA;
`ifdef LCD_ARB_TIMEOUT_EN
    assign bus.timeout   = r_timeout;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lcd_bus_arbiter.sv
// ============================================================================
// Module      : tb_lcd_bus_arbiter
// Description : Self-checking bench for lcd_bus_arbiter: vector table of
//               single-byte bursts, hand-written reset/timeout sequences and
//               randomized bursts checked against a burst-level round-robin
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_bus_arbiter;
    localparam int NR  = 3;
    localparam int EH  = 2;
    localparam int BSY = 40;
    localparam int CLR = 1600;
    localparam int TO  = 10;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clock = ~clock;

    lcd_bus_arbiter_if #(.NUM_REQ(NR)) bus ();

    lcd_bus_arbiter #(
        .NUM_REQ(NR), .E_HIGH_CYCLES(EH), .BUSY_CYCLES(BSY),
        .CLEAR_CYCLES(CLR), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [2:0] v;
        logic       rs;
        logic [7:0] d;
        logic [2:0] g;
        int         n;
    } vec_t;

    typedef struct {
        logic       rs;
        logic [7:0] d;
        logic       last;
    } byte_t;

    typedef struct {
        int         r;
        logic       rs;
        logic [7:0] d;
    } exp_t;

    byte_t mem [NR][16];
    int    cnt [NR];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_busy",  32'(bus.busy), 0);
        chk("rst_E",     32'(bus.E), 0);
        chk("rst_RS",    32'(bus.RS), 0);
        chk("rst_DATA",  32'(bus.DATA), 0);
        chk("rst_RW",    32'(bus.RW), 0);
        chk("rst_ready", 32'(bus.req_ready), 0);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // One byte from acceptance to the end of its wait; stimulus set by caller.
    task automatic byte_check(input logic [2:0] eg, input logic rs, input logic [7:0] d,
                              input int n, input bit last, input string nm);
        int k;
        k = 0;
        while (bus.req_ready == 3'b000 && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk({nm, "_grant"}, 32'(bus.grant), 32'(eg));
        chk({nm, "_ready"}, 32'(bus.req_ready), 32'(eg));
        @(negedge clock);
        bus.req_valid = '0;
        chk({nm, "_setupE"}, 32'(bus.E), 0);
        chk({nm, "_RS"},     32'(bus.RS), 32'(rs));
        chk({nm, "_DATA"},   32'(bus.DATA), 32'(d));
        k = 0;
        @(negedge clock);
        while (bus.E == 1'b1 && k < 20) begin
            k++;
            @(negedge clock);
        end
        chk({nm, "_Ewidth"}, 32'(k), 32'(EH));
        k = 0;
        while (!(bus.grant == 3'b000 || bus.req_ready != 3'b000) && k < n + 50) begin
            k++;
            @(negedge clock);
        end
        chk({nm, "_wait"}, 32'(k), 32'(n + 1));
        if (last) begin
            chk({nm, "_rel_grant"}, 32'(bus.grant), 0);
            chk({nm, "_rel_busy"},  32'(bus.busy), 0);
        end else begin
            chk({nm, "_next_ready"}, 32'(bus.req_ready), 32'(eg));
        end
    endtask

    // Drives the bytes in mem/cnt and checks the LCD writes against a
    // burst-level round-robin model of who should own the bus when.
    task automatic run_engine(input string nm, input int budget);
        exp_t         expq[$];
        exp_t         e;
        int           mp[NR];
        int           ptr[NR];
        int           gap[NR];
        int           rr, c, w, cyc;
        bit           any, done, pe;
        logic [NR-1:0] fire;

        rr = NR - 1;
        for (int i = 0; i < NR; i++) mp[i] = 0;
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            for (int k = 1; k <= NR; k++) begin
                c = (rr + k) % NR;
                if (!any && mp[c] < cnt[c]) begin
                    any = 1'b1;
                    rr  = c;
                    forever begin
                        e.r = c; e.rs = mem[c][mp[c]].rs; e.d = mem[c][mp[c]].d;
                        expq.push_back(e);
                        mp[c]++;
                        if (mem[c][mp[c]-1].last || mp[c] >= cnt[c]) break;
                    end
                end
            end
        end

        for (int i = 0; i < NR; i++) begin ptr[i] = 0; gap[i] = 0; end
        fire = '0; pe = 1'b0; w = 0; done = 1'b0;
        for (cyc = 0; cyc < budget && !done; cyc++) begin
            @(negedge clock);
            for (int i = 0; i < NR; i++) if (fire[i]) ptr[i]++;
            if (bus.E && !pe) begin
                if (expq.size() == 0) begin
                    chk({nm, "_extra_pulse"}, 32'(bus.DATA), 32'hFFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    chk({nm, "_owner"}, 32'(bus.grant), 32'(1) << e.r);
                    chk({nm, "_RS"},    32'(bus.RS), 32'(e.rs));
                    chk({nm, "_DATA"},  32'(bus.DATA), 32'(e.d));
                    chk({nm, "_RW"},    32'(bus.RW), 0);
                end
            end
            if (bus.E) w++;
            else if (pe) begin
                chk({nm, "_Ewidth"}, 32'(w), 32'(EH));
                w = 0;
            end
            pe = bus.E;
            for (int i = 0; i < NR; i++) begin
                if (ptr[i] < cnt[i]) begin
                    if (bus.grant[i] && gap[i] < 3 && $urandom_range(0, 3) == 0) begin
                        bus.req_valid[i] = 1'b0;
                        gap[i]++;
                    end else begin
                        bus.req_valid[i] = 1'b1;
                        gap[i] = 0;
                    end
                    bus.req_rs[i]          = mem[i][ptr[i]].rs;
                    bus.req_data[8*i +: 8] = mem[i][ptr[i]].d;
                    bus.req_last[i]        = mem[i][ptr[i]].last;
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
            end
            fire = bus.req_valid & bus.req_ready;
            done = (expq.size() == 0) && !bus.busy && (bus.req_valid == '0);
        end
        chk({nm, "_done"}, 32'(done), 1);
        chk({nm, "_left"}, 32'(expq.size()), 0);
        bus.req_valid = '0;
    endtask

    task automatic gen_random();
        int nb, len;
        for (int i = 0; i < NR; i++) begin
            cnt[i] = 0;
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                len = $urandom_range(1, 3);
                for (int j = 0; j < len; j++) begin
                    if ($urandom_range(0, 31) == 0) begin
                        mem[i][cnt[i]].rs = 1'b0;
                        mem[i][cnt[i]].d  = 8'($urandom_range(1, 3));
                    end else begin
                        mem[i][cnt[i]].rs = 1'($urandom_range(0, 1));
                        mem[i][cnt[i]].d  = 8'($urandom);
                    end
                    mem[i][cnt[i]].last = (j == len - 1);
                    cnt[i]++;
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   k;

        tbl[0] = '{3'b001, 1'b1, 8'h41, 3'b001, BSY};
        tbl[1] = '{3'b111, 1'b0, 8'h01, 3'b010, CLR};
        tbl[2] = '{3'b111, 1'b1, 8'h01, 3'b100, BSY};
        tbl[3] = '{3'b111, 1'b0, 8'h02, 3'b001, CLR};
        tbl[4] = '{3'b101, 1'b0, 8'h03, 3'b100, CLR};
        tbl[5] = '{3'b011, 1'b0, 8'h04, 3'b001, BSY};
        tbl[6] = '{3'b011, 1'b0, 8'h00, 3'b010, BSY};
        tbl[7] = '{3'b001, 1'b1, 8'hFF, 3'b001, BSY};

        bus.req_valid = '0; bus.req_rs = '0; bus.req_data = '0; bus.req_last = '0;
        do_reset();

        for (int i = 0; i < 8; i++) begin
            bus.req_rs    = {NR{tbl[i].rs}};
            bus.req_data  = {NR{tbl[i].d}};
            bus.req_last  = '1;
            bus.req_valid = tbl[i].v;
            byte_check(tbl[i].g, tbl[i].rs, tbl[i].d, tbl[i].n, 1'b1, $sformatf("vec%0d", i));
        end

        // Reset while E is high: everything drops at once, then req0 wins.
        bus.req_rs = '1; bus.req_data = {NR{8'hA5}}; bus.req_last = '1;
        bus.req_valid = 3'b010;
        k = 0;
        while (bus.E == 1'b0 && k < 30) begin @(negedge clock); k++; end
        chk("midrst_Ehigh", 32'(bus.E), 1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_E",     32'(bus.E), 0);
        chk("midrst_grant", 32'(bus.grant), 0);
        chk("midrst_DATA",  32'(bus.DATA), 0);
        chk("midrst_RS",    32'(bus.RS), 0);
        chk("midrst_busy",  32'(bus.busy), 0);
        @(negedge clock);
        reset = 1'b0;
        bus.req_data = {NR{8'h55}};
        bus.req_valid = 3'b111;
        byte_check(3'b001, 1'b1, 8'h55, BSY, 1'b1, "post_rst");

`ifdef LCD_ARB_TIMEOUT_EN
        do_reset();
        bus.req_rs = '1; bus.req_data = {NR{8'h33}}; bus.req_last = '0;
        bus.req_valid = 3'b100;
        byte_check(3'b100, 1'b1, 8'h33, BSY, 1'b0, "to_byte");
        bus.req_data = {NR{8'h5A}}; bus.req_last = '1;
        bus.req_valid = 3'b001;
        k = 1;
        @(negedge clock);
        while (bus.req_ready[2] && k < 40) begin k++; @(negedge clock); end
        chk("to_cycles",  32'(k), 32'(TO));
        chk("to_pulse",   32'(bus.timeout), 1);
        chk("to_grant0",  32'(bus.grant), 0);
        @(negedge clock);
        chk("to_pulse_end", 32'(bus.timeout), 0);
        chk("to_next_grant", 32'(bus.grant), 32'(3'b001));
        byte_check(3'b001, 1'b1, 8'h5A, BSY, 1'b1, "post_to");
`endif

        // Burst lock: a 4-byte burst from req0 is not split by req1.
        do_reset();
        cnt[0] = 4; cnt[1] = 1; cnt[2] = 0;
        for (int j = 0; j < 4; j++) mem[0][j] = '{1'b1, 8'(8'h10 + j), (j == 3)};
        mem[1][0] = '{1'b1, 8'h20, 1'b1};
        run_engine("lock", 2000);

        for (int r = 0; r < 2; r++) begin
            do_reset();
            gen_random();
            run_engine($sformatf("rand%0d", r), 30000);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
